segment_stepper: RTL and testbench

- Downstream consumer of the byte-record fifo. Dequeues one 16-byte motion record at a time, latches it, and executes it.
- Execution is a multi-axis Bresenham/DDA: direction outputs are set up first, then step pulses are emitted at a programmable period.
- Drives the step/dir pins of the stepper drivers directly.

---
 rtl/motion_pkg.sv | 36 +++
 rtl/step_pulse_gen.sv | 43 ++++
 rtl/segment_stepper.sv | 191 +++++++++++++++++++
 tb/tb_segment_stepper.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and record layout for the segment stepper.
package motion_pkg;

    localparam int unsigned MaxAxes     = 4;
    localparam int unsigned RecordBytes = 16;
    localparam int unsigned FieldW      = 16;
    localparam int unsigned DirW        = 4;

    localparam int unsigned ByteTicks  = 0;
    localparam int unsigned BytePeriod = 2;
    localparam int unsigned ByteAxis   = 4;
    localparam int unsigned ByteDir    = 12;
    // Everything above the dir nibble is reserved.
    localparam int unsigned UsedBits   = 8 * ByteDir + DirW;

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    typedef struct packed {
        logic [DirW-1:0]                dir;
        logic [MaxAxes-1:0][FieldW-1:0] axis;
        logic [FieldW-1:0]              period;
        logic [FieldW-1:0]              ticks;
    } motion_record_t;

    function automatic motion_record_t unpack_record(input logic [UsedBits-1:0] raw);
        motion_record_t r;
        r.ticks  = raw[8*ByteTicks +: FieldW];
        r.period = raw[8*BytePeriod +: FieldW];
        for (int i = 0; i < MaxAxes; i++) begin
            r.axis[i] = raw[8*ByteAxis + i*FieldW +: FieldW];
        end
        r.dir = raw[8*ByteDir +: DirW];
        return r;
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Stretches a one-cycle fire strobe into a registered step pulse PulseWidth cycles wide.
module step_pulse_gen #(
    parameter int unsigned PulseWidth = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    output logic step,
    output logic active
);

    localparam int unsigned CntW = $clog2(PulseWidth + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_q, step_d;

    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        if (fire) begin
            step_d = 1'b1;
            cnt_d  = CntW'(PulseWidth - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end else begin
            step_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign step   = step_q;
    assign active = step_q;

endmodule

// File: rtl/segment_stepper.sv
// Dequeues 16-byte motion records and executes them as a multi-axis DDA driving step/dir pins.
// Define STEP_POSITION_EN to add per-axis signed 32-bit position counters.
module segment_stepper
    import motion_pkg::*;
#(
    parameter int unsigned NumAxes    = 4,
    parameter int unsigned PulseWidth = 8,
    parameter int unsigned DirSetup   = 16,
    parameter int unsigned RecordBits = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [RecordBits-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic [NumAxes-1:0]    step,
    output logic [NumAxes-1:0]    dir,
    output logic                  busy,
    output logic                  segment_done,
    output logic                  clamp_err
`ifdef STEP_POSITION_EN
    ,
    output logic [NumAxes*32-1:0] position
`endif
);

    localparam int unsigned SetupW  = $clog2(DirSetup + 1);
    localparam logic [16:0] PeffMin = 17'(2 * PulseWidth);

    state_t                     state_q, state_d;
    logic [15:0]                n_q, n_d;
    logic [16:0]                peff_q, peff_d;
    logic [NumAxes-1:0][15:0]   axis_q, axis_d;
    logic [NumAxes-1:0][16:0]   err_q, err_d;
    logic [NumAxes-1:0]         dir_q, dir_d;
    logic [SetupW-1:0]          setup_cnt_q, setup_cnt_d;
    logic [16:0]                period_cnt_q, period_cnt_d;
    logic [15:0]                tick_cnt_q, tick_cnt_d;
    logic                       clamp_q, clamp_d;

    logic [NumAxes-1:0][16:0]   sum;
    logic [NumAxes-1:0]         fire;
    logic [NumAxes-1:0]         pulse_active;
    logic                       tick;
    motion_record_t             rec;
    logic                       unused_rsvd;

    assign rec         = unpack_record(fifo_data[UsedBits-1:0]);
    assign unused_rsvd = ^fifo_data[RecordBits-1:UsedBits];

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        peff_d       = peff_q;
        axis_d       = axis_q;
        err_d        = err_q;
        dir_d        = dir_q;
        setup_cnt_d  = setup_cnt_q;
        period_cnt_d = period_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        clamp_d      = clamp_q;
        fire         = '0;
        tick         = 1'b0;
        for (int i = 0; i < NumAxes; i++) begin
            sum[i] = err_q[i] + {1'b0, axis_q[i]};
        end
        fifo_read_en = (state_q == IDLE) && enable && !fifo_empty && !reset;

        unique case (state_q)
            IDLE: begin
                if (fifo_read_en) begin
                    n_d    = rec.ticks;
                    peff_d = ({1'b0, rec.period} > PeffMin) ? {1'b0, rec.period} : PeffMin;
                    for (int i = 0; i < NumAxes; i++) begin
                        if (rec.axis[i] > rec.ticks) begin
                            axis_d[i] = rec.ticks;
                            clamp_d   = 1'b1;
                        end else begin
                            axis_d[i] = rec.axis[i];
                        end
                        err_d[i] = {2'b00, rec.ticks[15:1]};
                    end
                    // dir is loaded here so it is already valid in the first SETUP cycle.
                    dir_d        = rec.dir[NumAxes-1:0];
                    setup_cnt_d  = '0;
                    period_cnt_d = '0;
                    tick_cnt_d   = '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SetupW'(DirSetup - 1)) begin
                    period_cnt_d = '0;
                    state_d      = (n_q == 16'd0) ? DONE : RUN;
                end else begin
                    setup_cnt_d = setup_cnt_q + SetupW'(1);
                end
            end
            RUN: begin
                if (enable) begin
                    if (period_cnt_q == peff_q - 17'd1) begin
                        period_cnt_d = '0;
                        tick         = (tick_cnt_q != n_q);
                    end else begin
                        period_cnt_d = period_cnt_q + 17'd1;
                    end
                end
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 16'd1;
                    for (int i = 0; i < NumAxes; i++) begin
                        if (sum[i] >= {1'b0, n_q}) begin
                            fire[i]  = 1'b1;
                            err_d[i] = sum[i] - {1'b0, n_q};
                        end else begin
                            err_d[i] = sum[i];
                        end
                    end
                end
                if ((tick_cnt_q == n_q) && !(|pulse_active)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            peff_q       <= '0;
            axis_q       <= '0;
            err_q        <= '0;
            dir_q        <= '0;
            setup_cnt_q  <= '0;
            period_cnt_q <= '0;
            tick_cnt_q   <= '0;
            clamp_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            peff_q       <= peff_d;
            axis_q       <= axis_d;
            err_q        <= err_d;
            dir_q        <= dir_d;
            setup_cnt_q  <= setup_cnt_d;
            period_cnt_q <= period_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            clamp_q      <= clamp_d;
        end
    end

    for (genvar g = 0; g < NumAxes; g++) begin : g_axis
        step_pulse_gen #(
            .PulseWidth(PulseWidth)
        ) u_pulse (
            .clk   (clk),
            .reset (reset),
            .fire  (fire[g]),
            .step  (step[g]),
            .active(pulse_active[g])
        );
    end

`ifdef STEP_POSITION_EN
    logic [NumAxes-1:0][31:0] pos_q;

    // Updates on the same edge the step pin rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            for (int i = 0; i < NumAxes; i++) begin
                if (fire[i]) begin
                    pos_q[i] <= dir_q[i] ? pos_q[i] + 32'd1 : pos_q[i] - 32'd1;
                end
            end
        end
    end

    assign position = pos_q;
`endif

    assign dir          = dir_q;
    assign busy         = (state_q != IDLE);
    assign segment_done = (state_q == DONE);
    assign clamp_err    = clamp_q;

endmodule

// File: tb/tb_segment_stepper.sv
// Bench for segment_stepper: record table with scoreboard, plus pause and mid-segment reset sequences.
module tb_segment_stepper;

    localparam int PW  = 8;
    localparam int DS  = 16;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [127:0] fifo_data;
    logic         fifo_read_en;
    logic [3:0]   step;
    logic [3:0]   dir;
    logic         busy;
    logic         segment_done;
    logic         clamp_err;

    segment_stepper #(
        .NumAxes   (4),
        .PulseWidth(PW),
        .DirSetup  (DS),
        .RecordBits(128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .step        (step),
        .dir         (dir),
        .busy        (busy),
        .segment_done(segment_done),
        .clamp_err   (clamp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      n;
        logic [15:0]      p;
        logic [3:0][15:0] a;
        logic [3:0]       dir;
        logic [3:0][15:0] exp_steps;
        int               exp_gap;
        logic             exp_clamp;
    } seg_vec_t;

    // Simple record fifo model; head advances on the dequeue edge.
    logic [127:0] fifo_mem [0:15];
    int unsigned  wr_ptr = 0;
    int unsigned  rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = fifo_mem[rd_ptr[3:0]];
    always @(posedge clk) if (fifo_read_en) rd_ptr <= rd_ptr + 1;

    seg_vec_t sb_q [$];
    int checks   = 0;
    int failures = 0;

    // Pin monitor
    int         cyc = 0;
    int         rises [4];
    int         hi_len [4];
    int         width_min = 0, width_max = 0, gap0_min = 0, gap0_max = 0;
    int         last_rise0 = -1, last_dir_change = 0, last_done_cyc = -1, read_gap = -1;
    int         dir_viol = 0, setup_viol = 0;
    logic [3:0] prev_step = '0;
    logic [3:0] prev_dir = '0;

    always @(negedge clk) begin
        cyc++;
        if (fifo_read_en === 1'b1) begin
            for (int i = 0; i < 4; i++) rises[i] = 0;
            width_min  = 1 << 30;
            width_max  = 0;
            gap0_min   = 1 << 30;
            gap0_max   = 0;
            last_rise0 = -1;
            read_gap   = (last_done_cyc >= 0) ? cyc - last_done_cyc : -1;
        end
        if (segment_done === 1'b1) last_done_cyc = cyc;
        if (dir !== prev_dir) begin
            last_dir_change = cyc;
            if (reset === 1'b0 && (step | prev_step) != 4'b0) dir_viol++;
        end
        for (int i = 0; i < 4; i++) begin
            if (step[i] === 1'b1 && prev_step[i] !== 1'b1) begin
                rises[i]++;
                hi_len[i] = 1;
                if (cyc - last_dir_change < DS) setup_viol++;
                if (i == 0) begin
                    if (last_rise0 >= 0) begin
                        if (cyc - last_rise0 < gap0_min) gap0_min = cyc - last_rise0;
                        if (cyc - last_rise0 > gap0_max) gap0_max = cyc - last_rise0;
                    end
                    last_rise0 = cyc;
                end
            end else if (step[i] === 1'b1) begin
                hi_len[i]++;
            end else if (prev_step[i] === 1'b1) begin
                if (hi_len[i] < width_min) width_min = hi_len[i];
                if (hi_len[i] > width_max) width_max = hi_len[i];
            end
        end
        prev_step = step;
        prev_dir  = dir;
    end

    function automatic seg_vec_t mk(input int n, input int p, input int a0, input int a1,
                                    input int a2, input int a3, input logic [3:0] d,
                                    input int e0, input int e1, input int e2, input int e3,
                                    input int gap, input logic clamp);
        seg_vec_t v;
        v.n   = 16'(n);
        v.p   = 16'(p);
        v.a   = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        v.dir = d;
        v.exp_steps = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
        v.exp_gap   = gap;
        v.exp_clamp = clamp;
        return v;
    endfunction

    // Reserved bytes and the upper dir nibble are filled with junk the DUT must ignore.
    function automatic logic [127:0] make_rec(input seg_vec_t v);
        return {24'hC3A55A, 4'hF, v.dir, v.a[3], v.a[2], v.a[1], v.a[0], v.p, v.n};
    endfunction

    task automatic push(input seg_vec_t v, input bit to_sb);
        fifo_mem[wr_ptr[3:0]] = make_rec(v);
        wr_ptr++;
        if (to_sb) sb_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (segment_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check({name, " segment_done seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_rises(input string name, input int target);
        bit seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (rises[0] >= target) begin
                seen = 1;
                break;
            end
        end
        check({name, " axis0 pulse seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_segment(input string name, input bit chk_read_gap);
        seg_vec_t e;
        int       total;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: actual=empty required=entry", name);
            return;
        end
        e = sb_q.pop_front();
        total = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s steps axis%0d", name, i), 64'(rises[i]), 64'(e.exp_steps[i]));
            total += int'(e.exp_steps[i]);
        end
        check({name, " dir"}, 64'(dir), 64'(e.dir));
        check({name, " clamp_err"}, 64'(clamp_err), 64'(e.exp_clamp));
        check({name, " busy at done"}, 64'(busy), 64'd1);
        if (total > 0) begin
            check({name, " width_min"}, 64'(width_min), 64'(PW));
            check({name, " width_max"}, 64'(width_max), 64'(PW));
        end
        if (e.exp_gap != 0) begin
            check({name, " gap0_min"}, 64'(gap0_min), 64'(e.exp_gap));
            check({name, " gap0_max"}, 64'(gap0_max), 64'(e.exp_gap));
        end
        if (chk_read_gap) check({name, " dequeue after done"}, 64'(read_gap), 64'd1);
    endtask

    seg_vec_t vecs [5];
    seg_vec_t vp, vr, v8;
    int       saved, now_sum, n_reads, n_busy;

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) fifo_mem[i] = '0;

        //            N   P   A0 A1 A2 A3  dir      exp steps   gap clamp
        vecs[0] = mk(4,  20, 4, 2, 1, 0, 4'b0101, 4, 2, 1, 0, 20, 1'b0);
        vecs[1] = mk(3,   3, 3, 0, 0, 1, 4'b1010, 3, 0, 0, 1, 16, 1'b0);
        vecs[2] = mk(2,  20, 5, 1, 0, 0, 4'b0001, 2, 1, 0, 0, 20, 1'b1);
        vecs[3] = mk(0,  20, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0,  0, 1'b1);
        vecs[4] = mk(5,  17, 3, 5, 0, 2, 4'b0110, 3, 5, 0, 2,  0, 1'b1);
        for (int k = 0; k < 5; k++) push(vecs[k], 1'b1);

        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("reset outputs c%0d", c),
                  64'({fifo_read_en, step, dir, busy, segment_done, clamp_err}), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("read_en after reset", 64'(fifo_read_en), 64'd1);
        @(negedge clk); #1;
        check("read_en single cycle", 64'(fifo_read_en), 64'd0);

        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("v%0d", k));
            check_segment($sformatf("v%0d", k), k > 0);
        end

        // Pause mid-RUN with a pulse in flight.
        vp = mk(6, 40, 6, 3, 0, 0, 4'b0011, 6, 3, 0, 0, 0, 1'b1);
        @(posedge clk); #1;
        push(vp, 1'b1);
        wait_rises("pause", 2);
        @(posedge clk); #1;
        check("pause pulse in flight", 64'(step[0]), 64'd1);
        enable = 1'b0;
        saved  = rises[0] + rises[1] + rises[2] + rises[3];
        repeat (50) @(posedge clk);
        @(negedge clk); #1;
        now_sum = rises[0] + rises[1] + rises[2] + rises[3];
        check("pause no new pulses", 64'(now_sum), 64'(saved));
        check("pause step low", 64'(step), 64'd0);
        check("pause busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_done("pause");
        check_segment("pause", 1'b0);

        // Reset in the middle of RUN.
        vr = mk(8, 30, 8, 8, 8, 8, 4'b1100, 8, 8, 8, 8, 0, 1'b0);
        @(posedge clk); #1;
        push(vr, 1'b0);
        wait_rises("midreset", 1);
        @(posedge clk); #1;
        check("midreset pulse in flight", 64'(step[0]), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset outputs",
              64'({fifo_read_en, step, dir, busy, segment_done, clamp_err}), 64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        n_reads = 0;
        n_busy  = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (fifo_read_en === 1'b1) n_reads++;
            if (busy !== 1'b0) n_busy++;
        end
        check("no dequeue when empty", 64'(n_reads), 64'd0);
        check("idle after reset", 64'(n_busy), 64'd0);

        v8 = mk(3, 16, 1, 2, 3, 0, 4'b1001, 1, 2, 3, 0, 0, 1'b0);
        @(posedge clk); #1;
        enable = 1'b0;
        push(v8, 1'b1);
        n_reads = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (fifo_read_en === 1'b1) n_reads++;
        end
        check("no dequeue when disabled", 64'(n_reads), 64'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk); #1;
        check("dequeue on enable", 64'(fifo_read_en), 64'd1);
        wait_done("post_reset");
        check_segment("post_reset", 1'b0);

        check("dir change while step high", 64'(dir_viol), 64'd0);
        check("dir setup before step", 64'(setup_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
